// File: rtl/icmp_pkg.sv
// Shared constants, FSM encoding and the ones-complement adder for the ICMP echo responder.
package icmp_pkg;

  localparam logic [7:0]  ICMP_TYPE_ECHO_REQ   = 8'd8;
  localparam logic [7:0]  ICMP_TYPE_ECHO_REPLY = 8'd0;
  localparam logic [15:0] IP_HDR_BYTES         = 16'd20;
  localparam logic [7:0]  PROTO_ICMP           = 8'h01;
  // ~m for m = 16'h0800, the type/code word of an echo request
  localparam logic [15:0] CSUM_TYPE_ADJ        = 16'hF7FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_PAY,
    ST_CHECK,
    ST_TX_HDR,
    ST_TX_PAY,
    ST_DRAIN
  } state_t;

  // 16-bit ones-complement add with end-around carry; the fold cannot carry again
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/icmp_buf_ram.sv
// Payload buffer: one write port, one synchronous read port (data valid the cycle after the address).
module icmp_buf_ram
  import icmp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  // write port and registered read port; contents need no reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    rd_data_q <= mem[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/icmp_echo_responder.sv
// ICMP echo responder: buffers one request, validates it and streams back an echo reply.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for an rx IP header (hdr_ready high once out of reset)
//  ST_RX_PAY | storing ICMP bytes into the buffer
//  ST_CHECK  | one cycle: validate frame, compute reply checksum
//  ST_TX_HDR | presenting the reply IP header
//  ST_TX_PAY | streaming reply bytes
//  ST_DRAIN  | swallowing the rest of an oversized frame
module icmp_echo_responder
  import icmp_pkg::*;
#(
  parameter int         MAX_BYTES = 64,
  parameter logic [7:0] TTL       = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        s_ip_hdr_valid,
  output logic        s_ip_hdr_ready,
  input  logic [15:0] s_ip_length,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,
  input  logic [7:0]  s_ip_payload_axis_tdata,
  input  logic        s_ip_payload_axis_tvalid,
  input  logic        s_ip_payload_axis_tlast,
  input  logic        s_ip_payload_axis_tuser,
  output logic        s_ip_payload_axis_tready,
  output logic        m_ip_hdr_valid,
  input  logic        m_ip_hdr_ready,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [15:0] m_ip_length,
  output logic [7:0]  m_ip_ttl,
  output logic [7:0]  m_ip_protocol,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,
  output logic [7:0]  m_ip_payload_axis_tdata,
  output logic        m_ip_payload_axis_tvalid,
  output logic        m_ip_payload_axis_tlast,
  output logic        m_ip_payload_axis_tuser,
  input  logic        m_ip_payload_axis_tready,
  output logic [15:0] o_drop_count
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int AW = $clog2(MAX_BYTES);

  state_t      state_q, state_d;
  logic        init_q, init_d;
  logic [15:0] len_q, len_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d, tx_idx_q, tx_idx_d;
  logic        bad_q, bad_d;
  logic [7:0]  type_q, type_d, code_q, code_d;
  logic [15:0] req_csum_q, req_csum_d, csum_q, csum_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [15:0] drop_q, drop_d;

  logic          rx_beat, tx_beat, hdr_rx, hdr_tx;
  logic          frame_ok, overflow;
  logic [CW-1:0] nxt_idx;
  logic [7:0]    nxt_byte, ram_rd_data;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_wr_en;

  assign rx_beat  = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready;
  assign tx_beat  = tvalid_q && m_ip_payload_axis_tready;
  assign hdr_rx   = s_ip_hdr_valid && s_ip_hdr_ready;
  assign hdr_tx   = m_ip_hdr_valid && m_ip_hdr_ready;
  assign overflow = (state_q == ST_RX_PAY) && rx_beat && !s_ip_payload_axis_tlast
                    && (cnt_q == CW'(MAX_BYTES - 1));
  assign frame_ok = !bad_q && (16'(cnt_q) == (len_q - IP_HDR_BYTES)) && (cnt_q >= CW'(8))
                    && (type_q == ICMP_TYPE_ECHO_REQ) && (code_q == 8'd0);
  assign ram_wr_en = (state_q == ST_RX_PAY) && rx_beat;

  icmp_buf_ram #(.DEPTH(MAX_BYTES), .AW(AW)) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (ram_wr_en),
    .i_wr_addr (cnt_q[AW-1:0]),
    .i_wr_data (s_ip_payload_axis_tdata),
    .i_rd_addr (ram_rd_addr),
    .o_rd_data (ram_rd_data)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hdr_rx) state_d = ST_RX_PAY;
      ST_RX_PAY: if (rx_beat && s_ip_payload_axis_tlast) state_d = ST_CHECK;
                 else if (overflow)                      state_d = ST_DRAIN;
      ST_CHECK:  state_d = frame_ok ? ST_TX_HDR : ST_IDLE;
      ST_TX_HDR: if (hdr_tx) state_d = ST_TX_PAY;
      ST_TX_PAY: if (tx_beat && tlast_q) state_d = ST_IDLE;
      ST_DRAIN:  if (rx_beat && s_ip_payload_axis_tlast) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state-decoded handshake outputs and reply header constants
  always_comb begin
    s_ip_hdr_ready           = (state_q == ST_IDLE) && init_q;
    s_ip_payload_axis_tready = (state_q == ST_RX_PAY) || (state_q == ST_DRAIN);
    m_ip_hdr_valid           = (state_q == ST_TX_HDR);
    m_ip_ttl                 = (state_q == ST_TX_HDR) ? TTL : 8'd0;
    m_ip_protocol            = (state_q == ST_TX_HDR) ? PROTO_ICMP : 8'd0;
  end

  // buffer read address runs one byte ahead of the output register, so ram_rd_data
  // always holds byte tx_idx_q+1 and the stream sustains one byte per cycle
  always_comb begin
    ram_rd_addr = '0;
    if (state_q == ST_TX_HDR)      ram_rd_addr = AW'(1);
    else if (state_q == ST_TX_PAY) ram_rd_addr = tx_idx_q[AW-1:0] + (tx_beat ? AW'(2) : AW'(1));
  end

  // datapath next values: header latches, rx capture, checksum, tx output register, drop counter
  always_comb begin
    init_d     = 1'b1;
    len_d      = len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    type_d     = type_q;
    code_d     = code_q;
    req_csum_d = req_csum_q;
    csum_d     = csum_q;
    tx_idx_d   = tx_idx_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    drop_d     = drop_q;

    nxt_idx = tx_idx_q + CW'(1);
    if (nxt_idx == CW'(1))      nxt_byte = code_q;
    else if (nxt_idx == CW'(2)) nxt_byte = csum_q[15:8];
    else if (nxt_idx == CW'(3)) nxt_byte = csum_q[7:0];
    else                        nxt_byte = ram_rd_data;

    case (state_q)
      ST_IDLE: if (hdr_rx) begin
        len_d = s_ip_length;
        src_d = s_ip_source_ip;
        dst_d = s_ip_dest_ip;
        cnt_d = '0;
        bad_d = 1'b0;
      end
      ST_RX_PAY: if (rx_beat) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(0)) type_d = s_ip_payload_axis_tdata;
        if (cnt_q == CW'(1)) code_d = s_ip_payload_axis_tdata;
        if (cnt_q == CW'(2)) req_csum_d[15:8] = s_ip_payload_axis_tdata;
        if (cnt_q == CW'(3)) req_csum_d[7:0]  = s_ip_payload_axis_tdata;
        if (s_ip_payload_axis_tlast) bad_d = s_ip_payload_axis_tuser;
      end
      ST_CHECK: csum_d = ~ones_add(~req_csum_q, CSUM_TYPE_ADJ);
      ST_TX_HDR: if (hdr_tx) begin
        tx_idx_d = '0;
        tdata_d  = ICMP_TYPE_ECHO_REPLY;
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
      end
      ST_TX_PAY: if (tx_beat) begin
        if (tlast_q) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end else begin
          tx_idx_d = nxt_idx;
          tdata_d  = nxt_byte;
          tlast_d  = (nxt_idx == cnt_q - CW'(1));
        end
      end
      default: ;
    endcase

    if ((overflow || ((state_q == ST_CHECK) && !frame_ok)) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  // datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_q     <= 1'b0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      type_q     <= '0;
      code_q     <= '0;
      req_csum_q <= '0;
      csum_q     <= '0;
      tx_idx_q   <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      init_q     <= init_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      type_q     <= type_d;
      code_q     <= code_d;
      req_csum_q <= req_csum_d;
      csum_q     <= csum_d;
      tx_idx_q   <= tx_idx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      drop_q     <= drop_d;
    end
  end

  assign m_ip_dscp                = 6'd0;
  assign m_ip_ecn                 = 2'd0;
  assign m_ip_length              = len_q;
  assign m_ip_source_ip           = dst_q;
  assign m_ip_dest_ip             = src_q;
  assign m_ip_payload_axis_tdata  = tdata_q;
  assign m_ip_payload_axis_tvalid = tvalid_q;
  assign m_ip_payload_axis_tlast  = tlast_q;
  assign m_ip_payload_axis_tuser  = 1'b0;
  assign o_drop_count             = drop_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Directed bench for icmp_echo_responder: echo replies, checksum wrap, drops, overflow, stalls, reset.
module tb_icmp_echo_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_hdr_valid = 1'b0;
  logic        s_hdr_ready;
  logic [15:0] s_len = '0;
  logic [31:0] s_src = '0, s_dst = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic        s_tready;
  logic        m_hdr_valid;
  logic        m_hdr_ready = 1'b0;
  logic [5:0]  m_dscp;
  logic [1:0]  m_ecn;
  logic [15:0] m_len;
  logic [7:0]  m_ttl, m_proto;
  logic [31:0] m_src, m_dst;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        m_tready = 1'b0;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int hvld_cnt = 0;
  int tvld_cnt = 0;
  int rx_stalls;
  logic [7:0] req     [0:127];
  logic [7:0] exp_pay [0:127];

  always #5 clk = ~clk;

  icmp_echo_responder #(.MAX_BYTES(64), .TTL(8'd64)) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .s_ip_hdr_valid           (s_hdr_valid),
    .s_ip_hdr_ready           (s_hdr_ready),
    .s_ip_length              (s_len),
    .s_ip_source_ip           (s_src),
    .s_ip_dest_ip             (s_dst),
    .s_ip_payload_axis_tdata  (s_tdata),
    .s_ip_payload_axis_tvalid (s_tvalid),
    .s_ip_payload_axis_tlast  (s_tlast),
    .s_ip_payload_axis_tuser  (s_tuser),
    .s_ip_payload_axis_tready (s_tready),
    .m_ip_hdr_valid           (m_hdr_valid),
    .m_ip_hdr_ready           (m_hdr_ready),
    .m_ip_dscp                (m_dscp),
    .m_ip_ecn                 (m_ecn),
    .m_ip_length              (m_len),
    .m_ip_ttl                 (m_ttl),
    .m_ip_protocol            (m_proto),
    .m_ip_source_ip           (m_src),
    .m_ip_dest_ip             (m_dst),
    .m_ip_payload_axis_tdata  (m_tdata),
    .m_ip_payload_axis_tvalid (m_tvalid),
    .m_ip_payload_axis_tlast  (m_tlast),
    .m_ip_payload_axis_tuser  (m_tuser),
    .m_ip_payload_axis_tready (m_tready),
    .o_drop_count             (drop_count)
  );

  // activity monitor for frames that must produce no output
  always @(posedge clk) begin
    if (m_hdr_valid) hvld_cnt++;
    if (m_tvalid)    tvld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // request bytes 4.. are a ramp; reply echoes them with type 0 and the given checksum
  task automatic fill(input int n, input logic [7:0] c_hi, input logic [7:0] c_lo,
                      input logic [7:0] r_hi, input logic [7:0] r_lo);
    req[0] = 8'h08; req[1] = 8'h00; req[2] = c_hi; req[3] = c_lo;
    for (int k = 4; k < n; k++) req[k] = 8'(k * 7 + 3);
    for (int k = 0; k < n; k++) exp_pay[k] = req[k];
    exp_pay[0] = 8'h00; exp_pay[2] = r_hi; exp_pay[3] = r_lo;
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [31:0] src, input logic [31:0] dst,
                            input int n, input logic bad);
    int t;
    @(negedge clk);
    s_hdr_valid = 1'b1; s_len = len; s_src = src; s_dst = dst;
    t = 0;
    while (!s_hdr_ready && t < 200) begin @(negedge clk); t++; end
    check("rx_hdr_wait", 32'(t < 200), 1);
    @(negedge clk);
    s_hdr_valid = 1'b0;
    rx_stalls = 0;
    for (int k = 0; k < n; k++) begin
      s_tdata = req[k]; s_tvalid = 1'b1;
      s_tlast = (k == n - 1); s_tuser = (k == n - 1) && bad;
      t = 0;
      while (!s_tready && t < 200) begin @(negedge clk); t++; rx_stalls++; end
      if (t >= 200) break;
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic recv_reply(input logic [15:0] len, input logic [31:0] src, input logic [31:0] dst,
                            input int n, input logic stall, input int stop);
    int t, k;
    logic hstall, pstall;
    logic [7:0] pdata;
    logic pl;
    t = 0; hstall = 1'b0;
    while (t < 400) begin
      m_hdr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hstall) check("hdr_hold", {15'd0, m_hdr_valid, m_len}, {15'd0, 1'b1, len});
      if (m_hdr_valid && m_hdr_ready) break;
      hstall = m_hdr_valid;
      @(negedge clk); t++;
    end
    check("tx_hdr_wait", 32'(t < 400), 1);
    check("hdr_src", m_src, dst);
    check("hdr_dst", m_dst, src);
    check("hdr_len", 32'(m_len), 32'(len));
    check("hdr_proto_ttl", {16'd0, m_proto, m_ttl}, {16'd0, 8'h01, 8'd64});
    check("hdr_dscp_ecn", 32'({m_dscp, m_ecn}), 0);
    @(negedge clk);
    m_hdr_ready = 1'b0;
    k = 0; t = 0; pstall = 1'b0; pdata = '0; pl = 1'b0;
    while (k < stop && t < 2000) begin
      m_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pstall) check("pay_hold", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, pl, pdata});
      pstall = 1'b0;
      if (m_tvalid) begin
        if (m_tready) begin
          check($sformatf("pay_byte%0d", k), 32'({m_tuser, m_tlast, m_tdata}),
                32'({1'b0, (k == n - 1), exp_pay[k]}));
          k++;
        end else begin
          pstall = 1'b1; pdata = m_tdata; pl = m_tlast;
        end
      end
      @(negedge clk); t++;
    end
    check("pay_count", k, stop);
    m_tready = 1'b0;
  endtask

  task automatic expect_silent(input string tag);
    int h0, b0;
    h0 = hvld_cnt; b0 = tvld_cnt;
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    repeat (12) @(negedge clk);
    check(tag, hvld_cnt - h0 + tvld_cnt - b0, 0);
    m_hdr_ready = 1'b0; m_tready = 1'b0;
  endtask

  task automatic load_t1();
    fill(8, 8'hF7, 8'hFE, 8'hFF, 8'hFE);
    req[4] = 8'h00; req[5] = 8'h01; req[6] = 8'h00; req[7] = 8'h01;
    exp_pay[4] = 8'h00; exp_pay[5] = 8'h01; exp_pay[6] = 8'h00; exp_pay[7] = 8'h01;
    exp_pay[1] = 8'h00;
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_hdr_ready", 32'(s_hdr_ready), 0);
    check("rst_out_valid", {30'd0, m_hdr_valid, m_tvalid}, 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_hdr_fields", {m_len, m_ttl, m_proto}, 0);
    check("rst_addrs", m_src | m_dst, 0);
    rst_n = 1'b1;

    // echo request with hand-worked reply
    load_t1();
    send_frame(16'd28, 32'hac000005, 32'hac000002, 8, 1'b0);
    recv_reply(16'd28, 32'hac000005, 32'hac000002, 8, 1'b0, 8);

    // checksum wrap: F7FF -> 0000, FFFF -> 0800
    fill(8, 8'hF7, 8'hFF, 8'h00, 8'h00);
    send_frame(16'd28, 32'h0a000001, 32'h0a000002, 8, 1'b0);
    recv_reply(16'd28, 32'h0a000001, 32'h0a000002, 8, 1'b0, 8);
    fill(8, 8'hFF, 8'hFF, 8'h08, 8'h00);
    send_frame(16'd28, 32'h0a000003, 32'h0a000004, 8, 1'b0);
    recv_reply(16'd28, 32'h0a000003, 32'h0a000004, 8, 1'b0, 8);

    // drops: echo reply type, tuser on tlast, length mismatch, too short
    fill(8, 8'h12, 8'h34, 8'h00, 8'h00);
    req[0] = 8'h00;
    send_frame(16'd28, 32'h01020304, 32'h05060708, 8, 1'b0);
    expect_silent("silent_type0");
    fill(8, 8'h12, 8'h34, 8'h00, 8'h00);
    send_frame(16'd28, 32'h01020304, 32'h05060708, 8, 1'b1);
    expect_silent("silent_tuser");
    send_frame(16'd30, 32'h01020304, 32'h05060708, 8, 1'b0);
    expect_silent("silent_len");
    check("drop_after3", 32'(drop_count), 3);
    send_frame(16'd24, 32'h01020304, 32'h05060708, 4, 1'b0);
    expect_silent("silent_short");
    check("drop_short", 32'(drop_count), 4);

    // oversized frame fully drained, then a 64-byte frame answered (1234 -> 1A34)
    fill(100, 8'h12, 8'h34, 8'h00, 8'h00);
    send_frame(16'd120, 32'hc0a80001, 32'hc0a80002, 100, 1'b0);
    check("drain_no_stall", rx_stalls, 0);
    expect_silent("silent_oversize");
    check("drop_oversize", 32'(drop_count), 5);
    fill(64, 8'h12, 8'h34, 8'h1A, 8'h34);
    send_frame(16'd84, 32'hc0a80001, 32'hc0a80002, 64, 1'b0);
    recv_reply(16'd84, 32'hc0a80001, 32'hc0a80002, 64, 1'b0, 64);

    // 56-byte request (0000 -> 0800) without and with stalls, then back-to-back
    fill(56, 8'h00, 8'h00, 8'h08, 8'h00);
    send_frame(16'd76, 32'h0b0b0b0b, 32'h0c0c0c0c, 56, 1'b0);
    recv_reply(16'd76, 32'h0b0b0b0b, 32'h0c0c0c0c, 56, 1'b0, 56);
    send_frame(16'd76, 32'h0b0b0b0b, 32'h0c0c0c0c, 56, 1'b0);
    recv_reply(16'd76, 32'h0b0b0b0b, 32'h0c0c0c0c, 56, 1'b1, 56);
    load_t1();
    send_frame(16'd28, 32'hac000005, 32'hac000002, 8, 1'b0);
    recv_reply(16'd28, 32'hac000005, 32'hac000002, 8, 1'b1, 8);
    check("drop_unchanged", 32'(drop_count), 5);

    // reset mid-payload, then a fresh request
    fill(56, 8'h00, 8'h00, 8'h08, 8'h00);
    send_frame(16'd76, 32'h0b0b0b0b, 32'h0c0c0c0c, 56, 1'b0);
    recv_reply(16'd76, 32'h0b0b0b0b, 32'h0c0c0c0c, 56, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {30'd0, m_hdr_valid, m_tvalid}, 0);
    check("mid_rst_data", {15'd0, m_tlast, m_tdata, drop_count[7:0]}, 0);
    check("mid_rst_fields", {m_len, 15'd0, s_hdr_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_t1();
    send_frame(16'd28, 32'hac000005, 32'hac000002, 8, 1'b0);
    recv_reply(16'd28, 32'hac000005, 32'hac000002, 8, 1'b0, 8);
    check("drop_after_rst", 32'(drop_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
